// File: rtl/ball_render_engine_if.sv
// ball_render_engine_if: register-bridge, VGA timing and pixel-result signals of the ball engine.
interface ball_render_engine_if #(
    parameter int NUM_BALLS = 4,
    parameter int ID_W      = 2,
    parameter int COORD_W   = 10
);
    logic                 wr_en;
    logic [ID_W-1:0]      wr_ball;
    logic [1:0]           wr_field;
    logic [15:0]          wr_data;
    logic                 commit;
    logic                 commit_pending;
    logic                 frame_tick;
    logic                 VGA_VS;
    logic [COORD_W-1:0]   DrawX;
    logic [COORD_W-1:0]   DrawY;
    logic                 is_ball;
    logic [ID_W-1:0]      ballID;
    logic [NUM_BALLS-1:0] collide_flags;

    modport master (
        output wr_en, wr_ball, wr_field, wr_data, commit, VGA_VS, DrawX, DrawY,
        input  commit_pending, frame_tick, is_ball, ballID, collide_flags
    );
    modport slave (
        input  wr_en, wr_ball, wr_field, wr_data, commit, VGA_VS, DrawX, DrawY,
        output commit_pending, frame_tick, is_ball, ballID, collide_flags
    );
endinterface

// File: rtl/ball_render_engine.sv
// ball_render_engine: shadow/active ball registers with frame-synchronous commit and a 2-stage hit pipeline.
// Optional overlap detection enabled by defining BALL_RENDER_COLLISION_EN.
module ball_render_engine #(
    parameter int NUM_BALLS = 4,
    parameter int ID_W      = 2,
    parameter int COORD_W   = 10,
    parameter int RAD_W     = 6
) (
    input logic                 Clk,
    input logic                 Reset_n,
    ball_render_engine_if.slave bus
);
    typedef enum logic {IDLE, PENDING} state_t;

    state_t               state_q, state_d;
    logic [COORD_W-1:0]   sx_q [NUM_BALLS];
    logic [COORD_W-1:0]   sy_q [NUM_BALLS];
    logic [COORD_W-1:0]   ax_q [NUM_BALLS];
    logic [COORD_W-1:0]   ay_q [NUM_BALLS];
    logic [RAD_W-1:0]     sr_q [NUM_BALLS];
    logic [RAD_W-1:0]     ar_q [NUM_BALLS];
    logic [NUM_BALLS-1:0] se_q, ae_q;
    logic [COORD_W:0]     dx_q [NUM_BALLS];
    logic [COORD_W:0]     dy_q [NUM_BALLS];
    logic [NUM_BALLS-1:0] hit_d;
    logic                 vs_q, tick_q, boundary, copy, wr_ok;
    logic                 is_ball_q, is_ball_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic                 unused_wr_data;

    assign unused_wr_data = ^bus.wr_data;
    assign boundary = vs_q & ~bus.VGA_VS;
    assign wr_ok    = bus.wr_en && (int'(bus.wr_ball) < NUM_BALLS);

    // A commit arriving on the boundary cycle in IDLE only arms the copy for the next frame.
    always_comb begin
        state_d = (state_q == IDLE) ? (bus.commit ? PENDING : IDLE) : (boundary ? IDLE : PENDING);
        copy    = (state_q == PENDING) && boundary;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            vs_q      <= 1'b1;
            tick_q    <= 1'b0;
            is_ball_q <= 1'b0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            vs_q      <= bus.VGA_VS;
            tick_q    <= boundary;
            is_ball_q <= is_ball_d;
            id_q      <= id_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            se_q <= '0;
            ae_q <= '0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                sx_q[i] <= '0;
                sy_q[i] <= '0;
                sr_q[i] <= '0;
                ax_q[i] <= '0;
                ay_q[i] <= '0;
                ar_q[i] <= '0;
                dx_q[i] <= '0;
                dy_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (wr_ok && int'(bus.wr_ball) == i) begin
                    if (bus.wr_field == 2'd0) sx_q[i] <= bus.wr_data[COORD_W-1:0];
                    if (bus.wr_field == 2'd1) sy_q[i] <= bus.wr_data[COORD_W-1:0];
                    if (bus.wr_field == 2'd2) sr_q[i] <= bus.wr_data[RAD_W-1:0];
                    if (bus.wr_field == 2'd3) se_q[i] <= bus.wr_data[0];
                end
                if (copy) begin
                    ax_q[i] <= sx_q[i];
                    ay_q[i] <= sy_q[i];
                    ar_q[i] <= sr_q[i];
                    ae_q[i] <= se_q[i];
                end
                dx_q[i] <= {1'b0, bus.DrawX} - {1'b0, ax_q[i]};
                dy_q[i] <= {1'b0, bus.DrawY} - {1'b0, ay_q[i]};
            end
        end
    end

    // Squares are formed on sign-extended operands, so unsigned arithmetic yields the exact value.
    for (genvar b = 0; b < NUM_BALLS; b++) begin : g_hit
        logic [2*COORD_W+1:0] ex, ey;
        logic [2*COORD_W+2:0] d2, rx, rr;
        assign ex = {{(COORD_W+1){dx_q[b][COORD_W]}}, dx_q[b]};
        assign ey = {{(COORD_W+1){dy_q[b][COORD_W]}}, dy_q[b]};
        assign d2 = {1'b0, ex * ex} + {1'b0, ey * ey};
        assign rx = {{(2*COORD_W+3-RAD_W){1'b0}}, ar_q[b]};
        assign rr = rx * rx;
        assign hit_d[b] = ae_q[b] && (d2 <= rr);
    end

    always_comb begin
        id_d      = '0;
        is_ball_d = |hit_d;
        for (int i = NUM_BALLS - 1; i >= 0; i--)
            if (hit_d[i]) id_d = ID_W'(i);
    end

`ifdef BALL_RENDER_COLLISION_EN
    logic [NUM_BALLS-1:0] flags_q, flags_d;
    // More than one bit set in hit_d marks an overlap pixel.
    assign flags_d = (boundary ? '0 : flags_q) |
                     ((|(hit_d & (hit_d - NUM_BALLS'(1)))) ? hit_d : '0);
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) flags_q <= '0;
        else          flags_q <= flags_d;
    end
    assign bus.collide_flags = flags_q;
`else
    assign bus.collide_flags = '0;
`endif

    assign bus.commit_pending = (state_q == PENDING);
    assign bus.frame_tick     = tick_q;
    assign bus.is_ball        = is_ball_q;
    assign bus.ballID         = id_q;
endmodule

// File: tb/tb_ball_render_engine.sv
// tb_ball_render_engine: directed vectors for commit timing, hit geometry, priority and overlap flags.
module tb_ball_render_engine;
    localparam int NB = 4;
    localparam int IW = 3;
    localparam int CW = 10;
`ifdef BALL_RENDER_COLLISION_EN
    localparam bit COL = 1'b1;
`else
    localparam bit COL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   hits;

    ball_render_engine_if #(.NUM_BALLS(NB), .ID_W(IW), .COORD_W(CW)) bus ();

    ball_render_engine #(.NUM_BALLS(NB), .ID_W(IW), .COORD_W(CW), .RAD_W(6)) dut (
        .Clk    (clk),
        .Reset_n(rst_n),
        .bus    (bus)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int b, input int f, input int d);
        bus.wr_en    = 1'b1;
        bus.wr_ball  = IW'(b);
        bus.wr_field = 2'(f);
        bus.wr_data  = 16'(d);
        tick;
        bus.wr_en = 1'b0;
    endtask

    task automatic set_ball(input int b, input int x, input int y, input int r, input int en);
        wr(b, 0, x);
        wr(b, 1, y);
        wr(b, 2, r);
        wr(b, 3, en);
    endtask

    task automatic do_commit;
        bus.commit = 1'b1;
        tick;
        bus.commit = 1'b0;
    endtask

    task automatic vs_edge;
        bus.VGA_VS = 1'b0;
        tick;
        tick;
        bus.VGA_VS = 1'b1;
        tick;
    endtask

    task automatic probe(input string tag, input int x, input int y, input int hit, input int id);
        bus.DrawX = CW'(x);
        bus.DrawY = CW'(y);
        tick;
        tick;
        chk({tag, "_hit"}, 32'(bus.is_ball), 32'(hit));
        chk({tag, "_id"}, 32'(bus.ballID), 32'(id));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.wr_en = 1'b0; bus.wr_ball = '0; bus.wr_field = '0; bus.wr_data = '0;
        bus.commit = 1'b0; bus.VGA_VS = 1'b1; bus.DrawX = '0; bus.DrawY = '0;
        repeat (10) begin
            bus.wr_en    = 1'($urandom);
            bus.wr_ball  = IW'($urandom);
            bus.wr_field = 2'($urandom);
            bus.wr_data  = 16'($urandom);
            bus.commit   = 1'($urandom);
            tick;
        end
        bus.wr_en = 1'b0;
        bus.commit = 1'b0;
        chk("rst_is_ball", 32'(bus.is_ball), 0);
        chk("rst_id", 32'(bus.ballID), 0);
        chk("rst_pending", 32'(bus.commit_pending), 0);
        chk("rst_tick", 32'(bus.frame_tick), 0);
        chk("rst_flags", 32'(bus.collide_flags), 0);
        rst_n = 1'b1;
        tick;

        // Enabled ball in shadow only: a frame without commit must draw nothing.
        set_ball(0, 5, 5, 10, 1);
        vs_edge;
        hits = 0;
        for (int i = 0; i < 22; i++) begin
            bus.DrawX = CW'(i);
            bus.DrawY = CW'(5);
            tick;
            hits += int'(bus.is_ball);
        end
        chk("no_commit_draw", 32'(hits), 0);
        chk("no_commit_pending", 32'(bus.commit_pending), 0);
        wr(0, 3, 0);

        set_ball(1, 320, 240, 10, 1);
        do_commit;
        chk("pending_set", 32'(bus.commit_pending), 1);
        bus.VGA_VS = 1'b0;
        tick;
        chk("tick_pulse", 32'(bus.frame_tick), 1);
        chk("pending_clr", 32'(bus.commit_pending), 0);
        tick;
        chk("tick_single", 32'(bus.frame_tick), 0);
        bus.VGA_VS = 1'b1;
        tick;
        probe("b1_330_240", 330, 240, 1, 1);
        probe("b1_331_240", 331, 240, 0, 0);
        probe("b1_328_247", 328, 247, 0, 0);
        probe("b1_320_230", 320, 230, 1, 1);
        probe("lat_pre", 330, 240, 1, 1);
        bus.DrawX = CW'(331);
        tick;
        chk("lat_1cyc", 32'(bus.is_ball), 1);
        tick;
        chk("lat_2cyc", 32'(bus.is_ball), 0);

        // Shadow isolation.
        set_ball(2, 100, 100, 3, 1);
        do_commit;
        vs_edge;
        probe("iso_a", 100, 100, 1, 2);
        wr(2, 0, 200);
        probe("iso_old", 100, 100, 1, 2);
        probe("iso_new_miss", 200, 100, 0, 0);
        do_commit;
        vs_edge;
        probe("iso_new", 200, 100, 1, 2);
        probe("iso_old_miss", 100, 100, 0, 0);

        // Commit on the boundary cycle defers the copy by one frame.
        wr(2, 0, 300);
        bus.commit = 1'b1;
        bus.VGA_VS = 1'b0;
        tick;
        bus.commit = 1'b0;
        chk("race_pending", 32'(bus.commit_pending), 1);
        bus.VGA_VS = 1'b1;
        tick;
        probe("race_nocopy", 200, 100, 1, 2);
        vs_edge;
        probe("race_copy", 300, 100, 1, 2);

        // Write on the copy cycle: old shadow value goes active.
        wr(2, 0, 350);
        do_commit;
        bus.VGA_VS = 1'b0;
        bus.wr_en = 1'b1; bus.wr_ball = IW'(2); bus.wr_field = 2'd0; bus.wr_data = 16'd400;
        tick;
        bus.wr_en = 1'b0;
        bus.VGA_VS = 1'b1;
        tick;
        chk("wrcopy_pending", 32'(bus.commit_pending), 0);
        probe("wrcopy_old", 350, 100, 1, 2);
        probe("wrcopy_new_miss", 400, 100, 0, 0);
        do_commit;
        vs_edge;
        probe("wrcopy_new", 400, 100, 1, 2);

        // Priority, edge clipping and out-of-range ball index.
        set_ball(0, 50, 50, 2, 1);
        set_ball(2, 52, 50, 2, 1);
        set_ball(3, 0, 0, 5, 1);
        wr(4, 3, 0);
        wr(7, 3, 0);
        wr(5, 0, 999);
        do_commit;
        vs_edge;
        probe("prio_50_50", 50, 50, 1, 0);
        chk("flags_0_2", 32'(bus.collide_flags), COL ? 32'h5 : 32'h0);
        probe("prio_53_50", 53, 50, 1, 2);
        probe("clip_0_0", 0, 0, 1, 3);
        probe("clip_5_0", 5, 0, 1, 3);
        probe("clip_6_0", 6, 0, 0, 0);
        vs_edge;
        chk("flags_clr_a", 32'(bus.collide_flags), 0);

        // Overlap of balls 0 and 1 only.
        set_ball(1, 50, 52, 2, 1);
        wr(2, 3, 0);
        do_commit;
        vs_edge;
        probe("col_50_50", 50, 50, 1, 0);
        chk("flags_0_1", 32'(bus.collide_flags), COL ? 32'h3 : 32'h0);
        probe("col_away", 600, 400, 0, 0);
        chk("flags_sticky", 32'(bus.collide_flags), COL ? 32'h3 : 32'h0);
        vs_edge;
        chk("flags_clr_b", 32'(bus.collide_flags), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
